tm_infer_ctrl: RTL and testbench
================================

TM_INFER_CTRL -- requirements
Module: tm_infer_ctrl

Interface
REQ-001 Parameter: EVAL_LAT, default 2, datapath settle cycles from feature launch to class sample; legal range 1..15.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  feature vector offered.
REQ-005 in_feat  in  2  feature vector {x2,x1}.
REQ-006 in_ready  out  1  controller accepts a feature vector.
REQ-007 cfg_we  in  1  clause mask write strobe.
REQ-008 cfg_addr  in  3  clause index 0..7.
REQ-009 cfg_data  in  4  include mask {~x2,x2,~x1,x1}.
REQ-010 cfg_err  out  1  one-cycle pulse, write rejected.
REQ-011 dp_feat  out  2  feature register driven to shared inference datapath.
REQ-012 dp_ex  out  32  packed clause masks, clause n at bits [4n+3:4n].
REQ-013 dp_class  in  2  datapath class result, combinational from dp_feat/dp_ex.
REQ-014 res_valid  out  1  result available.
REQ-015 res_class  out  2  captured class.
REQ-016 res_ready  in  1  consumer takes result.
REQ-017 busy  out  1  state is not IDLE.
REQ-018 infer_cnt  out  16  completed inferences.

Function
REQ-019 States: IDLE, EVAL, HOLD; all outputs registered except in_ready, busy (decoded from state).
REQ-020 IDLE: in_ready=1; in_valid=1 at edge k -> dp_feat<=in_feat, settle counter<=EVAL_LAT-1, state<=EVAL.
REQ-021 EVAL: in_ready=0; counter decrements each edge; at counter=0 edge, res_class<=dp_class, res_valid<=1, state<=HOLD; res_valid first high at edge k+EVAL_LAT.
REQ-022 HOLD: res_valid and res_class stable until res_valid&res_ready at an edge -> res_valid<=0, infer_cnt+1, state<=IDLE.
REQ-023 res_ready while not in HOLD: no effect.
REQ-024 New input accepted no earlier than the edge after result handshake; max throughput one inference per EVAL_LAT+2 cycles with res_ready held high.
REQ-025 dp_feat and dp_ex constant throughout EVAL and HOLD.
REQ-026 cfg_we in IDLE: mask[cfg_addr]<=cfg_data; dp_ex updated at same edge.
REQ-027 cfg_we in IDLE with in_valid at same edge: both take effect; that inference uses the new mask.
REQ-028 cfg_we in EVAL or HOLD: masks unchanged, cfg_err=1 for exactly the following cycle; back-to-back rejected writes keep cfg_err high.
REQ-029 infer_cnt wraps 16'hFFFF -> 16'h0000, no flag.
REQ-030 No combinational path from in_valid, cfg_we or res_ready to any output except none; in_ready depends on state only.

Reset
REQ-031 rst high -> immediately, clock-independent: state=IDLE, dp_feat=0, all eight masks=0 (dp_ex=0), res_class=0, res_valid=0, cfg_err=0, infer_cnt=0, counter=0.
REQ-032 rst asserted in EVAL or HOLD: inference discarded, no count increment, no res_valid after release.
REQ-033 First input acceptable at first rising edge with rst low.

Verification
REQ-034 Reset, write masks 0..7 = C,9,C,6,5,C,1,3 in IDLE, in_feat=2'b11 -> dp_ex=32'h31C56C9C same edge; res_valid at accept+2 with res_class equal to dp_class sampled at that edge; infer_cnt=1 after handshake.
REQ-035 EVAL_LAT=5, res_ready low 10 cycles after res_valid -> res_valid, res_class stable all 10 cycles; in_ready=0 throughout; in_valid held high accepted only edge after handshake.
REQ-036 cfg_we addr 3 data F during EVAL -> mask 3 unchanged, cfg_err one cycle; same write in IDLE -> dp_ex[15:12]=F, cfg_err=0.
REQ-037 Simultaneous cfg_we (addr 0, data 0) and in_valid in IDLE -> dp_ex[3:0]=0 and dp_feat updated at same edge.
REQ-038 rst pulse mid-EVAL (between clock edges) -> outputs reset immediately, res_valid never asserts, infer_cnt unchanged at 0.
REQ-039 Force infer_cnt to FFFF via 65535 inferences, one more -> 0000.

Source files
------------

// File: rtl/tm_infer_ctrl.sv
// ---------------------------------------------------------------------------
// tm_infer_ctrl
// Sequencing controller for a shared Tsetlin-machine style inference
// datapath. It accepts one 2-bit feature vector at a time and drives it, plus
// eight 4-bit clause include masks, into the external datapath. It waits
// EVAL_LAT cycles for the combinational result to settle, captures the class,
// and holds the result until the consumer takes it.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid/in_feat         feature vector offer {x2,x1}
//   in_ready                 controller idle and accepting (state decode)
//   cfg_we/cfg_addr/cfg_data clause mask write {~x2,x2,~x1,x1}
//   cfg_err                  one-cycle pulse: write arrived while busy
//   dp_feat/dp_ex            feature register and packed masks to datapath
//   dp_class                 class from datapath (combinational)
//   res_valid/res_class      held result
//   res_ready                consumer handshake
//   busy                     not idle (state decode)
//   infer_cnt                completed inferences, wraps silently
// ---------------------------------------------------------------------------
module tm_infer_ctrl #(
    parameter int EVAL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  in_feat,
    output logic        in_ready,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [3:0]  cfg_data,
    output logic        cfg_err,
    output logic [1:0]  dp_feat,
    output logic [31:0] dp_ex,
    input  logic [1:0]  dp_class,
    output logic        res_valid,
    output logic [1:0]  res_class,
    input  logic        res_ready,
    output logic        busy,
    output logic [15:0] infer_cnt
);

    typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

    localparam logic [3:0] LAT_M1 = 4'(EVAL_LAT - 1);

    state_t          state, state_nx;
    logic [3:0]      cnt;
    logic [7:0][3:0] mask;
    logic            accept, capture, done;

    // Clause n lives at bits [4n+3:4n] simply by the packed layout.
    assign dp_ex = mask;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        done     = 1'b0;
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        case (state)
            IDLE: if (in_valid) begin
                accept   = 1'b1;
                state_nx = EVAL;
            end
            EVAL: if (cnt == 4'd0) begin
                capture  = 1'b1;
                state_nx = HOLD;
            end
            HOLD: if (res_ready) begin
                // res_valid is always high in HOLD, so res_ready alone is the handshake
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mask      <= '0;
            dp_feat   <= 2'd0;
            res_valid <= 1'b0;
            res_class <= 2'd0;
            cfg_err   <= 1'b0;
            infer_cnt <= 16'd0;
        end else begin
            state   <= state_nx;
            // Masks are frozen while an inference is in flight; a write then is flagged instead.
            cfg_err <= cfg_we && (state != IDLE);
            if (cfg_we && state == IDLE)
                mask[cfg_addr] <= cfg_data;
            if (accept) begin
                dp_feat <= in_feat;
                cnt     <= LAT_M1;
            end else if (state == EVAL && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                res_class <= dp_class;
                res_valid <= 1'b1;
            end
            if (done) begin
                res_valid <= 1'b0;
                infer_cnt <= infer_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tm_infer_ctrl.sv
module tb_tm_infer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic        in_valid, in_ready, cfg_we, cfg_err, res_valid, res_ready, busy;
  logic [1:0]  in_feat, dp_feat, dp_class, res_class;
  logic [2:0]  cfg_addr;
  logic [3:0]  cfg_data;
  logic [31:0] dp_ex;
  logic [15:0] infer_cnt;

  assign dp_class = dp_feat ^ dp_ex[1:0] ^ dp_ex[5:4];

  tm_infer_ctrl #(.EVAL_LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_feat(in_feat),
    .in_ready(in_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .dp_feat(dp_feat),
    .dp_ex(dp_ex), .dp_class(dp_class), .res_valid(res_valid),
    .res_class(res_class), .res_ready(res_ready), .busy(busy),
    .infer_cnt(infer_cnt)
  );

  logic        in_valid5, in_ready5, cfg_err5, res_valid5, res_ready5, busy5;
  logic [1:0]  in_feat5, dp_feat5, dp_class5, res_class5;
  logic [31:0] dp_ex5;
  logic [15:0] infer_cnt5;

  assign dp_class5 = dp_feat5 ^ dp_ex5[1:0] ^ dp_ex5[5:4];

  tm_infer_ctrl #(.EVAL_LAT(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_feat(in_feat5),
    .in_ready(in_ready5), .cfg_we(1'b0), .cfg_addr(3'd0),
    .cfg_data(4'd0), .cfg_err(cfg_err5), .dp_feat(dp_feat5),
    .dp_ex(dp_ex5), .dp_class(dp_class5), .res_valid(res_valid5),
    .res_class(res_class5), .res_ready(res_ready5), .busy(busy5),
    .infer_cnt(infer_cnt5)
  );

  logic [3:0] mtab [8];

  initial begin
    mtab = '{4'hC, 4'h9, 4'hC, 4'h6, 4'h5, 4'hC, 4'h1, 4'h3};
    in_valid = 1'b0; in_feat = 2'd0; cfg_we = 1'b0; cfg_addr = 3'd0;
    cfg_data = 4'd0; res_ready = 1'b0;
    in_valid5 = 1'b0; in_feat5 = 2'd0; res_ready5 = 1'b0;

    #2;
    chk("rst_dp_ex", dp_ex, 32'h0);
    chk("rst_dp_feat", dp_feat, 2'd0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_cnt", infer_cnt, 16'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = mtab[i];
      @(negedge clk);
    end
    cfg_we = 1'b0;
    chk("masks_dp_ex", dp_ex, 32'h31C56C9C);
    chk("masks_cfg_err", cfg_err, 1'b0);

    in_valid = 1'b1; in_feat = 2'b11;
    @(negedge clk);
    in_valid = 1'b0;
    chk("acc_dp_feat", dp_feat, 2'b11);
    chk("acc_in_ready", in_ready, 1'b0);
    chk("acc_busy", busy, 1'b1);
    chk("k0_res_valid", res_valid, 1'b0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("k1_res_valid", res_valid, 1'b0);
    @(negedge clk);
    chk("k2_res_valid", res_valid, 1'b1);
    chk("k2_res_class", res_class, 2'b10);
    @(negedge clk);
    res_ready = 1'b0;
    chk("hs_res_valid", res_valid, 1'b0);
    chk("hs_cnt", infer_cnt, 16'd1);
    chk("hs_in_ready", in_ready, 1'b1);

    in_valid = 1'b1; in_feat = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 4'hF;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("rej_cfg_err", cfg_err, 1'b1);
    chk("rej_dp_ex", dp_ex, 32'h31C56C9C);
    @(negedge clk);
    chk("rej_err_drop", cfg_err, 1'b0);
    chk("rej_res_valid", res_valid, 1'b1);
    chk("rej_res_class", res_class, 2'b00);
    cfg_we = 1'b1;
    @(negedge clk);
    chk("b2b_err1", cfg_err, 1'b1);
    @(negedge clk);
    cfg_we = 1'b0;
    chk("b2b_err2", cfg_err, 1'b1);
    @(negedge clk);
    chk("b2b_err_drop", cfg_err, 1'b0);
    chk("b2b_dp_ex", dp_ex, 32'h31C56C9C);
    chk("b2b_res_class", res_class, 2'b00);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("hs2_cnt", infer_cnt, 16'd2);

    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("idle_wr_dp_ex", dp_ex, 32'h31C5FC9C);
    chk("idle_wr_cfg_err", cfg_err, 1'b0);

    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 4'h0;
    in_valid = 1'b1; in_feat = 2'b10;
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("sim_dp_ex", dp_ex, 32'h31C5FC90);
    chk("sim_dp_feat", dp_feat, 2'b10);
    @(negedge clk);
    @(negedge clk);
    chk("sim_res_valid", res_valid, 1'b1);
    chk("sim_res_class", res_class, 2'b11);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("hs3_cnt", infer_cnt, 16'd3);

    in_valid = 1'b1; in_feat = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_dp_feat", dp_feat, 2'd0);
    chk("arst_dp_ex", dp_ex, 32'h0);
    chk("arst_cnt", infer_cnt, 16'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_no_valid", res_valid, 1'b0);
    end
    chk("arst_cnt_after", infer_cnt, 16'd0);

    force dut.infer_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.infer_cnt;
    @(negedge clk);
    chk("wrap_pre", infer_cnt, 16'hFFFF);
    in_valid = 1'b1; in_feat = 2'b00; res_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_valid", res_valid, 1'b1);
    @(negedge clk);
    res_ready = 1'b0;
    chk("wrap_cnt", infer_cnt, 16'h0000);

    in_valid5 = 1'b1; in_feat5 = 2'b11;
    @(negedge clk);
    chk("l5_acc_ready", in_ready5, 1'b0);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk("l5_eval_valid", res_valid5, 1'b0);
      chk("l5_eval_ready", in_ready5, 1'b0);
    end
    @(negedge clk);
    chk("l5_valid", res_valid5, 1'b1);
    chk("l5_class", res_class5, 2'b11);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("l5_hold_valid", res_valid5, 1'b1);
      chk("l5_hold_class", res_class5, 2'b11);
      chk("l5_hold_ready", in_ready5, 1'b0);
    end
    res_ready5 = 1'b1;
    @(negedge clk);
    res_ready5 = 1'b0;
    chk("l5_hs_valid", res_valid5, 1'b0);
    chk("l5_hs_cnt", infer_cnt5, 16'd1);
    chk("l5_hs_ready", in_ready5, 1'b1);
    @(negedge clk);
    in_valid5 = 1'b0;
    chk("l5_reacc_ready", in_ready5, 1'b0);
    chk("l5_reacc_busy", busy5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
